// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // Write-back source encoding that marks a load (data comes from data memory).
  localparam logic [1:0] RU_SRC_DM = 2'b01;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_flush;
    logic de_en;
    logic de_flush;
    logic em_en;
    logic mw_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b0, de_en: 1'b1,
                                     de_flush: 1'b0, em_en: 1'b1, mw_flush: 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b0, de_en: 1'b0,
                                     de_flush: 1'b0, em_en: 1'b0, mw_flush: 1'b1};
  localparam ctrl_t CTRL_KILL    = '{pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b1, de_en: 1'b0,
                                     de_flush: 1'b1, em_en: 1'b0, mw_flush: 1'b1};

endpackage

// File: rtl/hazard_mem_timer.sv
// Memory-wait cycle counter: load to 1 on entry, increment while waiting, flag expiry.
module hazard_mem_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

  logic [TMR_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (load) count <= TMR_W'(1);
    else if (clr)  count <= '0;
    else if (inc)  count <= count + TMR_W'(1);
  end

  assign expired = (count == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubble, branch flush, memory freeze with timeout.
// Optional HAZARD_PERF_EN adds saturating stall/flush/load-use counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [1:0] LOAD_SRC    = RU_SRC_DM
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  de_rs1,
  input  logic [4:0]  de_rs2,
  input  logic        de_use_rs1,
  input  logic        de_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_ru_write,
  input  logic [1:0]  ex_ru_data_src,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        fd_en,
  output logic        fd_flush,
  output logic        de_en,
  output logic        de_flush,
  output logic        em_en,
  output logic        mw_flush,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_lu_cnt,
`endif
  output logic        hazard_err
);

  state_e state, state_nxt;
  ctrl_t  ctrl;
  logic   load_use, resolve;
  logic   tmr_load, tmr_clr, tmr_inc, tmr_expired;

  assign load_use = ex_ru_write && (ex_ru_data_src == LOAD_SRC) && (ex_rd != 5'd0) &&
                    ((de_use_rs1 && (de_rs1 == ex_rd)) || (de_use_rs2 && (de_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    ctrl      = CTRL_DEFAULT;
    state_nxt = state;
    resolve   = 1'b0;
    tmr_load  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ack) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = MEM_WAIT;
          tmr_load  = 1'b1;
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ack) begin
          ctrl = CTRL_FREEZE;
          if (tmr_expired) state_nxt = ERR;
          else             tmr_inc   = 1'b1;
        end else begin
          resolve   = 1'b1;
          state_nxt = RUN;
          tmr_clr   = 1'b1;
        end
      end
      ERR:     ctrl = CTRL_KILL;
      default: begin
        ctrl      = CTRL_KILL;
        state_nxt = ERR;
      end
    endcase
    // A branch still held in EX after a freeze is flushed here, on the release cycle.
    if (resolve) begin
      if (ex_br_taken) begin
        ctrl.fd_flush = 1'b1;
        ctrl.de_flush = 1'b1;
      end else if (load_use) begin
        ctrl.pc_en    = 1'b0;
        ctrl.fd_en    = 1'b0;
        ctrl.de_flush = 1'b1;
      end
    end
    if (!rst_n) ctrl = CTRL_KILL;
  end

  hazard_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  assign pc_en      = ctrl.pc_en;
  assign fd_en      = ctrl.fd_en;
  assign fd_flush   = ctrl.fd_flush;
  assign de_en      = ctrl.de_en;
  assign de_flush   = ctrl.de_flush;
  assign em_en      = ctrl.em_en;
  assign mw_flush   = ctrl.mw_flush;
  assign hazard_err = (state == ERR);

`ifdef HAZARD_PERF_EN
  // Outside ERR, fd_flush only comes from a branch and pc_en=0 with de_flush=1 only from load-use.
  logic live;
  assign live = (state != ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      if (live && !pc_en && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (live && fd_flush && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (live && !pc_en && de_flush && perf_lu_cnt != '1) perf_lu_cnt <= perf_lu_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=16).
module tb_hazard_ctrl;

  localparam logic [6:0] E_DEF    = 7'b1101010;  // {pc,fd_en,fd_fl,de_en,de_fl,em,mw_fl}
  localparam logic [6:0] E_FREEZE = 7'b0000001;
  localparam logic [6:0] E_BR     = 7'b1111110;
  localparam logic [6:0] E_LU     = 7'b0001110;
  localparam logic [6:0] E_KILL   = 7'b0010101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] de_rs1, de_rs2, ex_rd;
  logic       de_use_rs1, de_use_rs2, ex_ru_write, ex_br_taken, mem_req, mem_ack;
  logic [1:0] ex_ru_data_src;
  logic       pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_flush, hazard_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_lu_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(16), .LOAD_SRC(2'b01)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .de_rs1         (de_rs1),
    .de_rs2         (de_rs2),
    .de_use_rs1     (de_use_rs1),
    .de_use_rs2     (de_use_rs2),
    .ex_rd          (ex_rd),
    .ex_ru_write    (ex_ru_write),
    .ex_ru_data_src (ex_ru_data_src),
    .ex_br_taken    (ex_br_taken),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .pc_en          (pc_en),
    .fd_en          (fd_en),
    .fd_flush       (fd_flush),
    .de_en          (de_en),
    .de_flush       (de_flush),
    .em_en          (em_en),
    .mw_flush       (mw_flush),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_lu_cnt    (perf_lu_cnt),
`endif
    .hazard_err     (hazard_err)
  );

  task automatic chk(input string tag, input logic [6:0] exp, input logic exp_err);
    logic [6:0] obs;
    obs = {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_flush};
    checks++;
    assert (obs === exp && hazard_err === exp_err) else begin
      errors++;
      $error("FAIL %s observed=%b err=%b expected=%b err=%b", tag, obs, hazard_err, exp, exp_err);
    end
  endtask

  // Advance one clock, then leave a margin before inputs change.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    de_rs1 = 5'd0; de_rs2 = 5'd0; de_use_rs1 = 1'b0; de_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_ru_write = 1'b0; ex_ru_data_src = 2'b00;
    ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic load_in_ex(input logic [4:0] rd, input logic [1:0] src);
    ex_rd = rd; ex_ru_write = 1'b1; ex_ru_data_src = src;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2 chk("reset_outputs", E_KILL, 1'b0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1 chk("after_reset", E_DEF, 1'b0);

    // Load-use on rs1: one bubble, then the bubble in EX clears the hazard.
    cyc(); load_in_ex(5'd5, 2'b01); de_rs1 = 5'd5; de_use_rs1 = 1'b1;
    #1 chk("lu_rs1", E_LU, 1'b0);
    cyc(); ex_ru_write = 1'b0;
    #1 chk("lu_after_bubble", E_DEF, 1'b0);

    cyc(); idle(); load_in_ex(5'd7, 2'b01); de_rs2 = 5'd7; de_use_rs2 = 1'b1;
    #1 chk("lu_rs2", E_LU, 1'b0);
    de_use_rs2 = 1'b0;
    #1 chk("rs2_not_used", E_DEF, 1'b0);
    de_use_rs2 = 1'b1; ex_ru_data_src = 2'b00;
    #1 chk("alu_src_no_lu", E_DEF, 1'b0);

    cyc(); idle(); load_in_ex(5'd0, 2'b01); de_rs1 = 5'd0; de_use_rs1 = 1'b1;
    #1 chk("rd_x0_no_stall", E_DEF, 1'b0);

    cyc(); idle(); load_in_ex(5'd9, 2'b01); de_rs1 = 5'd9; de_use_rs1 = 1'b1; ex_br_taken = 1'b1;
    #1 chk("branch_beats_lu", E_BR, 1'b0);

    // Memory wait: three frozen cycles, release on the ack cycle.
    cyc(); idle(); mem_req = 1'b1;
    #1 chk("mem_wait_1", E_FREEZE, 1'b0);
    cyc(); #1 chk("mem_wait_2", E_FREEZE, 1'b0);
    cyc(); #1 chk("mem_wait_3", E_FREEZE, 1'b0);
    cyc(); mem_ack = 1'b1;
    #1 chk("mem_release", E_DEF, 1'b0);
    cyc(); idle();
    #1 chk("back_in_run", E_DEF, 1'b0);

    cyc(); mem_req = 1'b1; mem_ack = 1'b1; load_in_ex(5'd3, 2'b01); de_rs2 = 5'd3; de_use_rs2 = 1'b1;
    #1 chk("req_ack_same_cycle_lu", E_LU, 1'b0);

    // Branch held in EX while frozen: flushed only when the ack releases it.
    cyc(); idle(); mem_req = 1'b1; ex_br_taken = 1'b1;
    #1 chk("frozen_branch_1", E_FREEZE, 1'b0);
    cyc(); #1 chk("frozen_branch_2", E_FREEZE, 1'b0);
    cyc(); mem_ack = 1'b1;
    #1 chk("frozen_branch_release", E_BR, 1'b0);
    cyc(); idle();
    #1 chk("after_frozen_branch", E_DEF, 1'b0);
`ifdef HAZARD_PERF_EN
    checks++;
    assert (perf_flush_cnt === 32'd2) else begin
      errors++;
      $error("FAIL perf_flush_cnt observed=%0d expected=2", perf_flush_cnt);
    end
`endif

    // Reset during MEM_WAIT returns straight to RUN.
    cyc(); mem_req = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0;
    #1 chk("reset_mid_wait", E_KILL, 1'b0);
    cyc(); rst_n = 1'b1; idle();
    #1 chk("run_after_mid_reset", E_DEF, 1'b0);

    // Timeout: 16 frozen cycles, ERR from cycle 17.
    cyc(); mem_req = 1'b1;
    #1 chk("timeout_c1", E_FREEZE, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      cyc();
      chk($sformatf("timeout_c%0d", i), E_FREEZE, 1'b0);
    end
    cyc(); #1 chk("timeout_err", E_KILL, 1'b1);
    cyc(); mem_ack = 1'b1; ex_br_taken = 1'b1;
    #1 chk("err_sticky_ack", E_KILL, 1'b1);
    cyc(); idle();
    #1 chk("err_sticky_idle", E_KILL, 1'b1);
    rst_n = 1'b0;
    #1 chk("err_cleared_by_reset", E_KILL, 1'b0);
    cyc(); rst_n = 1'b1;
    #1 chk("run_after_err_reset", E_DEF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
